// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-ported MEMU; one access every 5 cycles.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on contention (default: fixed priority to port 0).
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef MEM_WORD_WIDTH
`define MEM_WORD_WIDTH 16
`endif

module mem_arbiter #(
    parameter int ADDR_W = `MEM_ADDR_WIDTH,
    parameter int WORD_W = `MEM_WORD_WIDTH
) (
    input  logic              Global_clk,
    input  logic              Global_reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              Wr0,
    input  logic              Wr1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [WORD_W-1:0] Wdata0,
    input  logic [WORD_W-1:0] Wdata1,
    output logic              Ack0,
    output logic              Ack1,
    output logic [WORD_W-1:0] Rdata0,
    output logic [WORD_W-1:0] Rdata1,
    output logic              Mem_read_sig,
    output logic              Mem_write_sig,
    output logic              Mem_op_enable,
    output logic [ADDR_W-1:0] Mem_address,
    output logic [WORD_W-1:0] Mem_wdata,
    input  logic [WORD_W-1:0] Mem_rdata,
    output logic              Busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_win;
    logic                r_wr;
    logic                r_mem_rd;
    logic                r_mem_wr;
    logic                r_mem_en;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [WORD_W-1:0]   r_mem_wdata;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_busy;
    logic [WORD_W-1:0]   r_rdata0;
    logic [WORD_W-1:0]   r_rdata1;

    logic                w_any_req;
    logic                w_grant;
    logic                w_wr;
    logic [ADDR_W-1:0]   w_addr;
    logic [WORD_W-1:0]   w_wdata;

    assign w_any_req = Req0 | Req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // r_last holds the port served most recently; contention goes to the other one.
    logic r_last;

    assign w_grant = (Req0 && Req1) ? ~r_last : ~Req0;

    always_ff @(posedge Global_clk or posedge Global_reset) begin
        if (Global_reset)
            r_last <= 1'b1;
        else if (r_state == S_IDLE && w_any_req)
            r_last <= w_grant;
    end
`else
    assign w_grant = ~Req0;
`endif

    assign w_wr    = w_grant ? Wr1    : Wr0;
    assign w_addr  = w_grant ? Addr1  : Addr0;
    assign w_wdata = w_grant ? Wdata1 : Wdata0;

    always_ff @(posedge Global_clk or posedge Global_reset) begin
        if (Global_reset) begin
            r_state     <= S_IDLE;
            r_win       <= 1'b0;
            r_wr        <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_busy      <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= S_SETUP;
                        r_win       <= w_grant;
                        r_wr        <= w_wr;
                        r_mem_rd    <= ~w_wr;
                        r_mem_wr    <= w_wr;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_wdata;
                        r_busy      <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_state  <= S_STROBE;
                    r_mem_en <= 1'b1;
                end
                S_STROBE: begin
                    r_state  <= S_CAPTURE;
                    r_mem_en <= 1'b0;
                end
                S_CAPTURE: begin
                    // MEMU has had a full cycle since the enable edge; its data is settled.
                    r_state <= S_DONE;
                    if (!r_wr) begin
                        if (r_win)
                            r_rdata1 <= Mem_rdata;
                        else
                            r_rdata0 <= Mem_rdata;
                    end
                    r_mem_rd <= 1'b0;
                    r_mem_wr <= 1'b0;
                    r_ack0   <= ~r_win;
                    r_ack1   <= r_win;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mem_rd <= 1'b0;
                    r_mem_wr <= 1'b0;
                    r_mem_en <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign Ack0          = r_ack0;
    assign Ack1          = r_ack1;
    assign Rdata0        = r_rdata0;
    assign Rdata1        = r_rdata1;
    assign Mem_read_sig  = r_mem_rd;
    assign Mem_write_sig = r_mem_wr;
    assign Mem_op_enable = r_mem_en;
    assign Mem_address   = r_mem_addr;
    assign Mem_wdata     = r_mem_wdata;
    assign Busy          = r_busy;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default `MEM_ADDR_WIDTH, address width.
REQ-002 SHALL have parameter WORD_W, default `MEM_WORD_WIDTH, data word width.
REQ-003 SHALL have port Global_clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port Global_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports Req0/Req1  input  1  per-requester access request.
REQ-006 SHALL have ports Wr0/Wr1  input  1  per-requester direction: 1 write, 0 read.
REQ-007 SHALL have ports Addr0/Addr1  input  ADDR_W  per-requester address.
REQ-008 SHALL have ports Wdata0/Wdata1  input  WORD_W  per-requester write data.
REQ-009 SHALL have ports Ack0/Ack1  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports Rdata0/Rdata1  output  WORD_W  per-requester read data, registered.
REQ-011 SHALL have port Mem_read_sig  output  1  to MEMU Read_sig.
REQ-012 SHALL have port Mem_write_sig  output  1  to MEMU Write_sig.
REQ-013 SHALL have port Mem_op_enable  output  1  to MEMU Mem_op_enable; MEMU acts on its rising edge.
REQ-014 SHALL have port Mem_address  output  ADDR_W  to MEMU Address_in.
REQ-015 SHALL have port Mem_wdata  output  WORD_W  to MEMU Data_in.
REQ-016 SHALL have port Mem_rdata  input  WORD_W  from MEMU Data_out.
REQ-017 SHALL have port Busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, SETUP, STROBE, CAPTURE, DONE; no other reachable state.
REQ-019 IDLE: if any Req high at a rising edge, SHALL latch winner id, Wr, Addr, Wdata and go to SETUP; else stay IDLE.
REQ-020 SETUP: SHALL drive Mem_address/Mem_wdata from latched values, exactly one of Mem_read_sig/Mem_write_sig high, Mem_op_enable low; next STROBE.
REQ-021 STROBE: SHALL hold SETUP values and drive Mem_op_enable high for exactly one cycle; next CAPTURE.
REQ-022 CAPTURE: SHALL drive Mem_op_enable low, keep address/direction stable, and on a read load Mem_rdata into Rdata of the winner; next DONE.
REQ-023 DONE: SHALL pulse Ack of the winner high one cycle, drop Mem_read_sig/Mem_write_sig; next IDLE.
REQ-024 Latency SHALL be fixed: Ack high in the 4th cycle after the edge sampling Req; back-to-back throughput one access per 5 cycles.
REQ-025 Mem_read_sig and Mem_write_sig SHALL never be high together; both low in IDLE and DONE.
REQ-026 Requests SHALL be sampled only in IDLE; Req/Addr/Wdata changes after latch SHALL not affect the transaction in flight.
REQ-027 Req dropped mid-transaction SHALL not abort; Ack still issued.
REQ-028 Requester holding Req high through Ack SHALL be treated as a new request at the next IDLE edge.
REQ-029 Rdata of the non-winner and on writes SHALL hold its previous value.
REQ-030 All outputs SHALL be registered; no combinational path from Req to Mem_* or Ack.

Reset
REQ-031 Global_reset high SHALL immediately force state IDLE, all Mem_* outputs 0, Ack0/Ack1 0, Busy 0, Rdata0/Rdata1 0, last-served pointer to 1.
REQ-032 Reset mid-transaction SHALL abandon it with no Ack; if asserted in STROBE, Mem_op_enable SHALL fall asynchronously.
REQ-033 First arbitration SHALL occur at the first rising edge after Global_reset deasserts.

Configuration
REQ-034 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous Req0/Req1 in IDLE, SHALL grant the port not last served, then update pointer.
REQ-035 MEM_ARB_ROUND_ROBIN_EN undefined: SHALL grant port 0 whenever Req0 high (fixed priority); pointer unused.
REQ-036 Single-requester behaviour SHALL be identical in both builds.

Verification
REQ-037 Reset, Req0=1 Wr0=0 Addr0=0x0F, MEMU mem[0x0F]=0xF00F -> one Mem_op_enable pulse with Mem_read_sig=1, Rdata0=0xF00F, Ack0 at cycle 4.
REQ-038 Req1=1 Wr1=1 Addr1=0x03 Wdata1=0x1234 -> Mem_write_sig=1 during pulse, mem[0x03]=0x1234, Ack1 once, Rdata1 unchanged.
REQ-039 Req0,Req1 both held high, 4 transactions -> RR build grants 0,1,0,1; fixed build grants 0,0,0,0.
REQ-040 Global_reset during STROBE -> Mem_op_enable falls same time, no Ack, Busy 0, next request serviced normally.
REQ-041 Req0 pulsed one cycle only -> transaction completes, Ack0 at cycle 4; Addr0 changed after latch has no effect.
REQ-042 Every cycle check: never Mem_read_sig & Mem_write_sig; Mem_op_enable never high two consecutive cycles.
